// File: rtl/board_io_pkg.sv
// Shared constants and the seven-segment decoder for the board I/O front end.
package board_io_pkg;

  localparam logic [6:0] SEG_BLANK   = 7'h7F;
  localparam int         SYNC_STAGES = 2;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    return 7'h40;
      4'h1:    return 7'h79;
      4'h2:    return 7'h24;
      4'h3:    return 7'h30;
      4'h4:    return 7'h19;
      4'h5:    return 7'h12;
      4'h6:    return 7'h02;
      4'h7:    return 7'h78;
      4'h8:    return 7'h00;
      4'h9:    return 7'h10;
      4'hA:    return 7'h08;
      4'hB:    return 7'h03;
      4'hC:    return 7'h46;
      4'hD:    return 7'h21;
      4'hE:    return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

endpackage

// File: rtl/board_io_if.sv
// Core-facing bundle: conditioned inputs toward the core, display data back.
interface board_io_if #(
  parameter int N_SW  = 16,
  parameter int N_KEY = 4,
  parameter int N_HEX = 8
);
  logic [N_SW-1:0]    sw_sync;
  logic [N_KEY-1:0]   key_level;
  logic [N_KEY-1:0]   key_press;
  logic [N_KEY-1:0]   key_rel;
  logic               run_en;
  logic [4*N_HEX-1:0] hex_value;
  logic [N_HEX-1:0]   hex_blank;

  // Front end drives the conditioned signals and consumes display data.
  modport master (
    output sw_sync, key_level, key_press, key_rel, run_en,
    input  hex_value, hex_blank
  );

  // Core side.
  modport slave (
    input  sw_sync, key_level, key_press, key_rel, run_en,
    output hex_value, hex_blank
  );
endinterface

// File: rtl/key_debounce.sv
// One debounce channel: a level changes only after DEBOUNCE_CYCLES stable cycles.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic key_sync_n,   // synchronised pin, 0 = pressed
  output logic level,
  output logic press,
  output logic rel,
  output logic press_next    // press value being registered this cycle
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             k;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             level_d, level_q;
  logic             press_d, press_q;
  logic             rel_d, rel_q;

  assign k = ~key_sync_n;

  // Count while the input disagrees with the level; any agreement clears it.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned (no latch).
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (k != level_q) begin
      if (cnt_q == TERM) begin
        level_d = k;
        press_d = k;
        rel_d   = ~k;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State and pulses share one register stage, so pulses align with the level edge.
  always_ff @(posedge CLOCK_50) begin
    // NOTE: reset is synchronous; it is just a priority term on the next-state value.
    if (reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign level      = level_q;
  assign press      = press_q;
  assign rel        = rel_q;
  assign press_next = press_d;

endmodule

// File: rtl/board_io_frontend.sv
// Board-pin conditioning for the core: sync, debounce, run-enable, 7-seg drive.
module board_io_frontend
  import board_io_pkg::*;
#(
  parameter int N_SW            = 16,
  parameter int N_KEY           = 4,
  parameter int N_HEX           = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int STEP_KEY        = 1
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic [N_SW-1:0]    sw_raw,
  input  logic [N_KEY-1:0]   key_raw,
  input  logic               step_mode,
  output logic [7*N_HEX-1:0] hex_seg,
  board_io_if.master         core
);

  logic [SYNC_STAGES-1:0][N_SW-1:0]  sw_pipe_d, sw_pipe_q;
  logic [SYNC_STAGES-1:0][N_KEY-1:0] key_pipe_d, key_pipe_q;
  logic [SYNC_STAGES-1:0]            step_pipe_d, step_pipe_q;
  logic                              run_en_d, run_en_q;
  logic [7*N_HEX-1:0]                hex_seg_d, hex_seg_q;
  logic [N_KEY-1:0]                  key_level, key_press, key_rel, press_next;

  // Shift each asynchronous input one stage deeper; display and run-enable next values.
  always_comb begin
    sw_pipe_d   = {sw_pipe_q[SYNC_STAGES-2:0], sw_raw};
    key_pipe_d  = {key_pipe_q[SYNC_STAGES-2:0], key_raw};
    step_pipe_d = {step_pipe_q[SYNC_STAGES-2:0], step_mode};
    run_en_d    = step_pipe_q[SYNC_STAGES-1] ? press_next[STEP_KEY] : 1'b1;
    hex_seg_d   = '1;
    for (int i = 0; i < N_HEX; i++) begin
      hex_seg_d[7*i +: 7] = core.hex_blank[i] ? SEG_BLANK
                                              : hex_to_seg(core.hex_value[4*i +: 4]);
    end
  end

  // Synchronisers, run-enable and display registers.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sw_pipe_q   <= '0;
      key_pipe_q  <= '1;
      step_pipe_q <= '0;
      run_en_q    <= 1'b0;
      hex_seg_q   <= '1;
    end else begin
      sw_pipe_q   <= sw_pipe_d;
      key_pipe_q  <= key_pipe_d;
      step_pipe_q <= step_pipe_d;
      run_en_q    <= run_en_d;
      hex_seg_q   <= hex_seg_d;
    end
  end

  for (genvar g = 0; g < N_KEY; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .CLOCK_50   (CLOCK_50),
      .reset      (reset),
      .key_sync_n (key_pipe_q[SYNC_STAGES-1][g]),
      .level      (key_level[g]),
      .press      (key_press[g]),
      .rel        (key_rel[g]),
      .press_next (press_next[g])
    );
  end

  assign core.sw_sync   = sw_pipe_q[SYNC_STAGES-1];
  assign core.key_level = key_level;
  assign core.key_press = key_press;
  assign core.key_rel   = key_rel;
  assign core.run_en    = run_en_q;
  assign hex_seg        = hex_seg_q;

endmodule

// File: tb/tb_board_io_frontend.sv
// Directed bench for board_io_frontend with a short debounce window.
module tb_board_io_frontend;

  localparam int N_SW  = 16;
  localparam int N_KEY = 4;
  localparam int N_HEX = 8;
  localparam int DEB   = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic [N_SW-1:0]    sw_raw;
  logic [N_KEY-1:0]   key_raw;
  logic               step_mode;
  logic [7*N_HEX-1:0] hex_seg;

  int tests = 0;
  int fails = 0;
  int pulses;
  logic [6:0] seg_tbl [16];

  board_io_if #(.N_SW(N_SW), .N_KEY(N_KEY), .N_HEX(N_HEX)) bus ();

  board_io_frontend #(
    .N_SW(N_SW), .N_KEY(N_KEY), .N_HEX(N_HEX),
    .DEBOUNCE_CYCLES(DEB), .STEP_KEY(1)
  ) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .sw_raw    (sw_raw),
    .key_raw   (key_raw),
    .step_mode (step_mode),
    .hex_seg   (hex_seg),
    .core      (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    seg_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    reset         = 1'b1;
    sw_raw        = 16'hA5A5;
    key_raw       = 4'hF;
    step_mode     = 1'b0;
    bus.hex_value = '0;
    bus.hex_blank = '0;
    repeat (3) tick();

    // Reset state
    check("rst_hex",   hex_seg, {56{1'b1}});
    check("rst_run",   bus.run_en, 0);
    check("rst_level", bus.key_level, 0);
    check("rst_press", bus.key_press, 0);
    check("rst_rel",   bus.key_rel, 0);
    check("rst_sw",    bus.sw_sync, 0);

    reset = 1'b0;
    tick();
    check("sw_lat1", bus.sw_sync, 0);
    check("run_free_after_rst", bus.run_en, 1);
    tick();
    check("sw_lat2", bus.sw_sync, 16'hA5A5);

    // Clean press and release of key 0
    key_raw[0] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check("k0_level", bus.key_level[0], (i >= 6));
      check("k0_press", bus.key_press[0], (i == 6));
    end
    key_raw[0] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("k0_rel_level", bus.key_level[0], (i < 6));
      check("k0_rel",       bus.key_rel[0], (i == 6));
    end

    // Bouncing key 2 never reaches terminal count
    for (int i = 0; i < 20; i++) begin
      key_raw[2] = ((i % 4) < 2) ? 1'b0 : 1'b1;
      tick();
      check("k2_bounce_press", bus.key_press[2], 0);
      check("k2_bounce_rel",   bus.key_rel[2], 0);
    end
    key_raw[2] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("k2_hold_press", bus.key_press[2], 0);
      check("k2_hold_rel",   bus.key_rel[2], 0);
      check("k2_hold_level", bus.key_level[2], 0);
    end

    // Step mode: toggle latency, then three single steps on key 1
    step_mode = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("step_enter", bus.run_en, (i < 3));
    end
    pulses = 0;
    for (int p = 0; p < 3; p++) begin
      key_raw[1] = 1'b0;
      for (int i = 1; i <= 10; i++) begin
        tick();
        check("step_run",   bus.run_en, (i == 6));
        check("step_press", bus.key_press[1], (i == 6));
        if (bus.run_en) pulses++;
      end
      key_raw[1] = 1'b1;
      for (int i = 1; i <= 10; i++) begin
        tick();
        check("step_idle", bus.run_en, 0);
      end
    end
    check("step_count", pulses, 3);
    step_mode = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("step_exit", bus.run_en, (i >= 3));
    end

    // Display: directed digits with one blank, then the full nibble table
    bus.hex_value = 32'h0123ABCD;
    bus.hex_blank = 8'h80;
    tick();
    check("hex_directed", hex_seg,
          {7'h7F, 7'h79, 7'h24, 7'h30, 7'h08, 7'h03, 7'h46, 7'h21});
    bus.hex_blank = 8'h00;
    for (int n = 0; n < 16; n++) begin
      bus.hex_value = {8{4'(n)}};
      tick();
      check($sformatf("hex_nib_%0h", n), hex_seg, {8{seg_tbl[n]}});
    end
    bus.hex_blank = 8'hFF;
    tick();
    check("hex_all_blank", hex_seg, {56{1'b1}});

    // Reset mid-debounce on key 3
    key_raw[3] = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("mid_rst_level", bus.key_level, 0);
    check("mid_rst_run",   bus.run_en, 0);
    check("mid_rst_hex",   hex_seg, {56{1'b1}});
    reset = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("k3_level", bus.key_level[3], (i >= 6));
      check("k3_press", bus.key_press[3], (i == 6));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
